// File: rtl/timer_irq_source_pkg.sv
// Shared constants for timer_irq_source: register offsets, CTRL bit layout,
// mode codes and the FSM state encoding.
package timer_irq_source_pkg;

    localparam logic [1:0] TimerCTRL   = 2'd0;
    localparam logic [1:0] TimerPRESET = 2'd1;
    localparam logic [1:0] TimerCOUNT  = 2'd2;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/timer_irq_source.sv
// Memory-mapped down-counter timer driving one level-sensitive interrupt line.
// Define TIMER_AUTORELOAD_EN to make CTRL mode 01 an auto-reload mode.
module timer_irq_source
    import timer_irq_source_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    timer_state_e state_q, state_d;
    logic         enable_q, enable_d;
    logic         im_q, im_d;
    logic [31:0]  preset_q, preset_d;
    logic [31:0]  count_q, count_d;
    logic         irq_flag_q, irq_flag_d;
    logic [1:0]   mode;
    logic         auto_reload;
    logic [31:0]  ctrl_rd;

`ifdef TIMER_AUTORELOAD_EN
    logic [1:0]   mode_q, mode_d;
    assign mode = mode_q;
`else
    assign mode = MODE_ONESHOT;
`endif

    assign auto_reload = (mode == MODE_RELOAD);
    assign IRQ         = irq_flag_q & im_q;

    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
`ifdef TIMER_AUTORELOAD_EN
        mode_d     = mode_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                end
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!enable_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    enable_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes come last so a CTRL write overrides the FSM's own updates.
        if (We) begin
            case (Addr)
                TimerCTRL: begin
                    enable_d   = DIn[CTRL_EN_BIT];
                    im_d       = DIn[CTRL_IM_BIT];
                    irq_flag_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
                    mode_d     = DIn[CTRL_MODE_MSB:CTRL_MODE_LSB];
`endif
                end
                TimerPRESET: preset_d = DIn;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            enable_q   <= 1'b0;
            im_q       <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            mode_q     <= MODE_ONESHOT;
`endif
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
`ifdef TIMER_AUTORELOAD_EN
            mode_q     <= mode_d;
`endif
        end
    end

    always_comb begin
        ctrl_rd                              = '0;
        ctrl_rd[CTRL_EN_BIT]                 = enable_q;
        ctrl_rd[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
        ctrl_rd[CTRL_IM_BIT]                 = im_q;
    end

    always_comb begin
        DOut = '0;
        case (Addr)
            TimerCTRL:   DOut = ctrl_rd;
            TimerPRESET: DOut = preset_q;
            TimerCOUNT:  DOut = count_q;
            default:     DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed self-checking bench for timer_irq_source; follows the auto-reload
// path when TIMER_AUTORELOAD_EN is defined, the one-shot fallback otherwise.
module tb_timer_irq_source;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    logic [31:0] osCount [5] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};

    timer_irq_source dut (
        .clk  (clk),
        .rst  (rst),
        .Addr (Addr),
        .We   (We),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus write, landing on the next rising edge.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        We   = 1'b1;
        tick(1);
        We   = 1'b0;
        DIn  = '0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] expected);
        Addr = a;
        #1;
        checkOutput(tag, DOut, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not reach the end");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst  = 1'b1;
        We   = 1'b0;
        Addr = A_CTRL;
        DIn  = '0;
        tick(2);
        rst = 1'b0;
        #1;
        checkReg("reset ctrl", A_CTRL, 32'h0);
        checkReg("reset preset", A_PRESET, 32'h0);
        checkReg("reset count", A_COUNT, 32'h0);
        checkReg("reset rsvd", A_RSVD, 32'h0);
        checkOutput("reset irq", IRQ, 1'b0);

        // One-shot, PRESET=3: IRQ rises after E5 and stays up.
        applyStimulus(A_PRESET, 32'd3);
        applyStimulus(A_CTRL, 32'h9);
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            checkReg($sformatf("oneshot count e%0d", i), A_COUNT, osCount[i-1]);
            checkOutput($sformatf("oneshot irq e%0d", i), IRQ, (i == 5) ? 32'd1 : 32'd0);
        end
        tick(1);
        checkReg("oneshot ctrl after int", A_CTRL, 32'h8);
        checkOutput("oneshot irq held e6", IRQ, 1'b1);
        tick(2);
        checkOutput("oneshot irq held e8", IRQ, 1'b1);
        applyStimulus(A_CTRL, 32'h8);
        checkOutput("oneshot irq cleared", IRQ, 1'b0);
        checkReg("oneshot ctrl cleared", A_CTRL, 32'h8);

        // Disable mid-count: COUNT freezes at 6.
        applyStimulus(A_PRESET, 32'd10);
        applyStimulus(A_CTRL, 32'h9);
        tick(5);
        checkReg("disable count e5", A_COUNT, 32'd7);
        applyStimulus(A_CTRL, 32'h8);
        checkReg("disable count e6", A_COUNT, 32'd6);
        tick(3);
        checkReg("disable count frozen", A_COUNT, 32'd6);
        checkOutput("disable irq", IRQ, 1'b0);
        applyStimulus(A_COUNT, 32'h1234);
        checkReg("count write ignored", A_COUNT, 32'd6);
        applyStimulus(A_RSVD, 32'hFFFF_FFFF);
        checkReg("rsvd reads zero", A_RSVD, 32'h0);
        checkReg("rsvd write no preset", A_PRESET, 32'd10);
        checkReg("rsvd write no ctrl", A_CTRL, 32'h8);

        // Masked expiry never raises IRQ, and a CTRL write clears the flag.
        applyStimulus(A_PRESET, 32'd2);
        applyStimulus(A_CTRL, 32'h1);
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            checkOutput($sformatf("mask irq e%0d", i), IRQ, 1'b0);
        end
        checkReg("mask count", A_COUNT, 32'd0);
        checkReg("mask ctrl", A_CTRL, 32'h0);
        applyStimulus(A_CTRL, 32'h8);
        checkOutput("mask unmask irq", IRQ, 1'b0);
        tick(1);
        checkOutput("mask unmask irq later", IRQ, 1'b0);

        // PRESET 0 and 1 both expire on the first CNT edge.
        for (int p = 0; p < 2; p++) begin
            applyStimulus(A_PRESET, 32'(p));
            applyStimulus(A_CTRL, 32'h9);
            tick(3);
            checkOutput($sformatf("preset%0d irq", p), IRQ, 1'b1);
            checkReg($sformatf("preset%0d count", p), A_COUNT, 32'd0);
            applyStimulus(A_CTRL, 32'h8);
            checkOutput($sformatf("preset%0d irq clear", p), IRQ, 1'b0);
        end

        // CTRL write landing on the INT edge keeps the written Enable.
        applyStimulus(A_PRESET, 32'd2);
        applyStimulus(A_CTRL, 32'h9);
        tick(4);
        checkOutput("intwr irq e4", IRQ, 1'b1);
        applyStimulus(A_CTRL, 32'h9);
        checkReg("intwr ctrl kept", A_CTRL, 32'h9);
        checkOutput("intwr irq cleared", IRQ, 1'b0);
        tick(3);
        checkOutput("intwr irq e8", IRQ, 1'b0);
        tick(1);
        checkOutput("intwr irq e9", IRQ, 1'b1);
        applyStimulus(A_CTRL, 32'h8);
        checkOutput("intwr final clear", IRQ, 1'b0);

        applyStimulus(A_PRESET, 32'd4);
        applyStimulus(A_CTRL, 32'hB);
`ifdef TIMER_AUTORELOAD_EN
        checkReg("reload ctrl", A_CTRL, 32'hB);
        for (int i = 1; i <= 19; i++) begin
            tick(1);
            checkOutput($sformatf("reload irq e%0d", i), IRQ,
                        (i == 6 || i == 12 || i == 18) ? 32'd1 : 32'd0);
            if (i >= 2 && i <= 6) begin
                checkReg($sformatf("reload count e%0d", i), A_COUNT, 32'(6 - i));
            end
        end
`else
        checkReg("noreload ctrl", A_CTRL, 32'h9);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            checkOutput($sformatf("noreload irq e%0d", i), IRQ, (i >= 6) ? 32'd1 : 32'd0);
            if (i == 7) begin
                checkReg("noreload ctrl after int", A_CTRL, 32'h8);
            end
        end
`endif
        applyStimulus(A_CTRL, 32'h0);
        tick(4);
        checkOutput("stopped irq", IRQ, 1'b0);

        // Asynchronous reset in the middle of a count.
        applyStimulus(A_PRESET, 32'd7);
        applyStimulus(A_CTRL, 32'h9);
        tick(4);
        checkReg("midreset count before", A_COUNT, 32'd5);
        rst = 1'b1;
        #1;
        checkOutput("midreset irq", IRQ, 1'b0);
        checkReg("midreset count", A_COUNT, 32'h0);
        checkReg("midreset ctrl", A_CTRL, 32'h0);
        checkReg("midreset preset", A_PRESET, 32'h0);
        tick(1);
        rst = 1'b0;
        tick(3);
        checkReg("postreset count", A_COUNT, 32'h0);
        checkOutput("postreset irq", IRQ, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
